// File: rtl/encode.sv
// -----------------------------------------------------------------------------
// encode: Kyber ByteEncode_l packer (1 <= l <= 12).
//
// Takes 256 coefficients, four per input beat, keeps the low l bits of each
// and streams the resulting 32*l-byte string out as 64-bit words. The byte
// order matches the decode block's input, so encode followed by decode is an
// identity for any l.
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   i_start         one-cycle start pulse, latches i_l (ignored while running)
//   i_l             bits per coefficient, legal range 1..12
//   i_coeffs        four 12-bit lanes, lane 0 in the low bits
//   i_coeffs_valid  input beat valid
//   o_coeffs_ready  input beat accepted when valid && ready
//   o_obytes        output word, first string byte in [63:56]
//   o_obytes_valid  output word valid
//   i_obytes_ready  downstream ready
//   o_done          level, high once the final word has been accepted
//   o_obytes_debug  (ENCODE_DEBUG_EN only) shift history of accepted words
//
// Optional feature macro: ENCODE_DEBUG_EN
// -----------------------------------------------------------------------------
module encode #(
  parameter int NCOEF = 256,
  parameter int CW    = 12,
  parameter int LANES = 4,
  parameter int OW    = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [3:0]          i_l,
  input  logic [LANES*CW-1:0] i_coeffs,
  input  logic                i_coeffs_valid,
  output logic                o_coeffs_ready,
  output logic [OW-1:0]       o_obytes,
  output logic                o_obytes_valid,
  input  logic                i_obytes_ready,
  output logic                o_done
`ifdef ENCODE_DEBUG_EN
  ,
  output logic [3071:0]       o_obytes_debug
`endif
);

  localparam int AW    = 112;
  localparam int PW    = LANES * CW;
  localparam int BEATS = NCOEF / LANES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  l_reg;
  logic [AW-1:0] acc;
  logic [6:0]  fill;
  logic [6:0]  in_cnt;
  logic [5:0]  out_cnt;

  logic          out_hs;
  logic          in_hs;
  logic          start_ok;
  logic          last_word;
  logic [5:0]    bits_per_beat;
  logic [CW-1:0] mask;
  logic [PW-1:0] packed_bits;
  logic [6:0]    fill_after_out;
  logic [6:0]    fill_next;
  logic [AW-1:0] acc_next;
  logic [OW-1:0] word_next;

  // Next-state datapath for the accumulator. The output side is retired
  // first so new bits land directly above whatever survives the shift; the
  // ready term keeps fill below 64 before an append, so 63 + 48 always fits.
  always_comb begin
    bits_per_beat  = {l_reg, 2'b00};
    mask           = (CW'(1) << l_reg) - CW'(1);
    out_hs         = o_obytes_valid && i_obytes_ready;
    fill_after_out = out_hs ? (fill - 7'd64) : fill;
    o_coeffs_ready = (state == RUN) && (in_cnt < 7'(BEATS)) && (fill_after_out < 7'd64);
    in_hs          = i_coeffs_valid && o_coeffs_ready;

    packed_bits = '0;
    for (int n = 0; n < LANES; n++) begin
      packed_bits = packed_bits | (PW'(i_coeffs[n*CW +: CW] & mask) << (n * int'(l_reg)));
    end

    acc_next = out_hs ? (acc >> OW) : acc;
    if (in_hs) begin
      acc_next = acc_next | (AW'(packed_bits) << fill_after_out);
    end
    fill_next = fill_after_out + (in_hs ? {1'b0, bits_per_beat} : 7'd0);

    // The accumulator is LSB-first, the output word puts the first byte on top.
    word_next = '0;
    for (int i = 0; i < OW/8; i++) begin
      word_next[OW-1-8*i -: 8] = acc_next[8*i +: 8];
    end

    start_ok  = i_start && (i_l != 4'd0) && (i_l <= 4'd12) && (state != RUN);
    last_word = out_hs && (out_cnt == (bits_per_beat - 6'd1));
  end

  // Control FSM and registered outputs. A new word is loaded when the buffer
  // holds a full word and the output slot is free or being emptied this cycle;
  // while stalled the buffer cannot change, so the held word stays stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      l_reg          <= '0;
      acc            <= '0;
      fill           <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      o_obytes       <= '0;
      o_obytes_valid <= 1'b0;
      o_done         <= 1'b0;
`ifdef ENCODE_DEBUG_EN
      o_obytes_debug <= '0;
`endif
    end else if (start_ok) begin
      state          <= RUN;
      l_reg          <= i_l;
      acc            <= '0;
      fill           <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      o_obytes       <= '0;
      o_obytes_valid <= 1'b0;
      o_done         <= 1'b0;
`ifdef ENCODE_DEBUG_EN
      o_obytes_debug <= '0;
`endif
    end else if (state == RUN) begin
      acc  <= acc_next;
      fill <= fill_next;
      if (in_hs) begin
        in_cnt <= in_cnt + 7'd1;
      end
      if (out_hs) begin
        out_cnt <= out_cnt + 6'd1;
`ifdef ENCODE_DEBUG_EN
        o_obytes_debug <= {o_obytes_debug[3071-OW:0], o_obytes};
`endif
      end
      if ((fill_next >= 7'd64) && (!o_obytes_valid || out_hs)) begin
        o_obytes       <= word_next;
        o_obytes_valid <= 1'b1;
      end else if (out_hs) begin
        o_obytes_valid <= 1'b0;
      end
      if (last_word) begin
        state  <= DONE;
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encode.sv
// -----------------------------------------------------------------------------
// tb_encode: self-checking bench for the encode packer. Expected words come
// from a bit-level ByteEncode model and are queued when a packet is started;
// a negedge monitor pops and compares them as the DUT hands words off.
// -----------------------------------------------------------------------------
module tb_encode;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [3:0]    i_l;
  logic [47:0]   i_coeffs;
  logic          i_coeffs_valid;
  logic          o_coeffs_ready;
  logic [63:0]   o_obytes;
  logic          o_obytes_valid;
  logic          i_obytes_ready;
  logic          o_done;
`ifdef ENCODE_DEBUG_EN
  logic [3071:0] o_obytes_debug;
`endif

  int checks = 0;
  int errors = 0;

  logic [11:0] coef [256];
  logic [63:0] model_w [48];
  logic [63:0] exp_q [$];
  logic [63:0] recv_q [$];
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_word = '0;

  localparam int MODE_MOD16 = 0;
  localparam int MODE_ALLF  = 1;
  localparam int MODE_ALT   = 2;
  localparam int MODE_RANDL = 3;
  localparam int MODE_RAND  = 4;

  always #5 clk = ~clk;

  encode dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_l            (i_l),
    .i_coeffs       (i_coeffs),
    .i_coeffs_valid (i_coeffs_valid),
    .o_coeffs_ready (o_coeffs_ready),
    .o_obytes       (o_obytes),
    .o_obytes_valid (o_obytes_valid),
    .i_obytes_ready (i_obytes_ready),
    .o_done         (o_done)
`ifdef ENCODE_DEBUG_EN
    ,
    .o_obytes_debug (o_obytes_debug)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finishTb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Downstream ready: always high, or random when a run asks for stalls.
  initial begin
    i_obytes_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_obytes_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on each handshake, stability on stalls.
  always @(negedge clk) begin
    logic [63:0] exp_w;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 64'(o_obytes_valid), 64'd1);
        checkOutput("stall_word", o_obytes, prev_word);
      end
      if (o_obytes_valid && i_obytes_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_word", 64'(o_obytes_valid), 64'd0);
        end else begin
          exp_w = exp_q.pop_front();
          checkOutput("word", o_obytes, exp_w);
        end
        recv_q.push_back(o_obytes);
      end
      prev_stall = o_obytes_valid && !i_obytes_ready;
      prev_word  = o_obytes;
    end
  end

  // Software ByteEncode_l: coefficient m bit j -> string bit m*l+j,
  // string bit 8B+b -> byte B bit b, byte 8k lands in the top of word k.
  task automatic buildModel(input int l);
    logic [3071:0] str;
    logic [63:0]   w;
    str = '0;
    for (int m = 0; m < 256; m++)
      for (int j = 0; j < l; j++)
        str[m*l + j] = coef[m][j];
    for (int k = 0; k < 4*l; k++) begin
      w = '0;
      for (int i = 0; i < 8; i++)
        w[63-8*i -: 8] = str[8*(8*k + i) +: 8];
      model_w[k] = w;
      exp_q.push_back(w);
    end
  endtask

  task automatic genCoeffs(input int l, input int mode);
    for (int m = 0; m < 256; m++) begin
      case (mode)
        MODE_MOD16: coef[m] = 12'(m % 16);
        MODE_ALLF:  coef[m] = 12'hFFF;
        MODE_ALT:   coef[m] = (m % 2 == 0) ? 12'd1 : 12'd0;
        MODE_RANDL: coef[m] = 12'($urandom_range(0, (1 << l) - 1));
        default:    coef[m] = 12'($urandom_range(0, 4095));
      endcase
    end
  endtask

  // Runs one packet: start pulse, 64 beats (optionally with valid gaps and a
  // stray start mid-run), then waits for o_done. Returns early after
  // abort_at accepted beats, leaving the DUT mid-packet.
  task automatic applyStimulus(input int l, input int mode, input bit gaps,
                               input bit rdy_rand, input int abort_at, input bit inject_start);
    int  bpb;
    int  first_b;
    int  budget;
    bit  accepted;
    bit  lat_pending;
    genCoeffs(l, mode);
    recv_q.delete();
    buildModel(l);
    rand_ready = rdy_rand;
    bpb        = 4 * l;
    first_b    = (64 + bpb - 1) / bpb - 1;
    lat_pending = 1'b0;

    i_l     = 4'(l);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    checkOutput("done_clear", 64'(o_done), 64'd0);

    for (int b = 0; b < 64; b++) begin
      if (b == abort_at) begin
        i_coeffs_valid = 1'b0;
        return;
      end
      for (int n = 0; n < 4; n++)
        i_coeffs[12*n +: 12] = coef[4*b + n];
      if (inject_start && b == 30) begin
        i_start = 1'b1;
        i_l     = 4'd2;
      end
      accepted = 1'b0;
      budget   = 0;
      while (!accepted) begin
        i_coeffs_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        if (lat_pending) begin
          checkOutput("first_valid", 64'(o_obytes_valid), 64'd1);
          lat_pending = 1'b0;
        end
        accepted = i_coeffs_valid && o_coeffs_ready;
        if (accepted && b == first_b) begin
          checkOutput("pre_valid", 64'(o_obytes_valid), 64'd0);
          lat_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        budget++;
        if (budget > 500) begin
          checkOutput("beat_timeout", 64'(b), 64'd64);
          finishTb();
        end
      end
    end

    // Stray valid after the last beat must be ignored.
    i_coeffs_valid = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      if (lat_pending) begin
        checkOutput("first_valid", 64'(o_obytes_valid), 64'd1);
        lat_pending = 1'b0;
      end
      budget++;
    end while (!o_done && budget < 3000);
    checkOutput("done", 64'(o_done), 64'd1);
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    checkOutput("word_count", 64'(recv_q.size()), 64'(4*l));
    checkOutput("ready_after", 64'(o_coeffs_ready), 64'd0);
`ifdef ENCODE_DEBUG_EN
    for (int k = 0; k < 4*l; k++)
      checkOutput("debug_hist", o_obytes_debug[256*l-1-64*k -: 64], model_w[k]);
`endif
    @(posedge clk);
    #1;
    i_coeffs_valid = 1'b0;
  endtask

  task automatic pulseStart(input logic [3:0] l);
    i_l     = l;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  initial begin
    logic [3071:0] str;
    int            errs;
    i_rst          = 1'b1;
    i_start        = 1'b0;
    i_l            = 4'd0;
    i_coeffs       = '0;
    i_coeffs_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_obytes", o_obytes, 64'd0);
    checkOutput("rst_valid", 64'(o_obytes_valid), 64'd0);
    checkOutput("rst_ready", 64'(o_coeffs_ready), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);

    // Illegal l values leave the block idle.
    @(posedge clk);
    #1;
    i_coeffs_valid = 1'b1;
    pulseStart(4'd0);
    @(negedge clk);
    checkOutput("l0_ready", 64'(o_coeffs_ready), 64'd0);
    @(posedge clk);
    #1;
    pulseStart(4'd13);
    repeat (2) @(negedge clk);
    checkOutput("l13_ready", 64'(o_coeffs_ready), 64'd0);
    checkOutput("l13_done", 64'(o_done), 64'd0);
    @(posedge clk);
    #1;
    i_coeffs_valid = 1'b0;

    applyStimulus(4, MODE_MOD16, 1'b0, 1'b0, 64, 1'b0);
    foreach (recv_q[k]) checkOutput("l4_pattern", recv_q[k], 64'h1032547698BADCFE);

    applyStimulus(12, MODE_ALLF, 1'b0, 1'b0, 64, 1'b0);
    foreach (recv_q[k]) checkOutput("l12_ones", recv_q[k], 64'hFFFFFFFFFFFFFFFF);

    applyStimulus(1, MODE_ALT, 1'b0, 1'b0, 64, 1'b0);
    foreach (recv_q[k]) checkOutput("l1_alt", recv_q[k], 64'h5555555555555555);

    // Illegal start in DONE keeps o_done.
    pulseStart(4'd13);
    @(negedge clk);
    checkOutput("done_hold", 64'(o_done), 64'd1);
    @(posedge clk);
    #1;

    applyStimulus(10, MODE_RANDL, 1'b1, 1'b1, 64, 1'b1);
    errs = 0;
    if (recv_q.size() == 40) begin
      str = '0;
      for (int k = 0; k < 40; k++)
        for (int i = 0; i < 8; i++)
          str[8*(8*k + i) +: 8] = recv_q[k][63-8*i -: 8];
      for (int m = 0; m < 256; m++)
        if (str[m*10 +: 10] !== coef[m][9:0]) errs++;
    end else begin
      errs = 256;
    end
    checkOutput("decode_l10", 64'(errs), 64'd0);

    // Mid-packet reset after 20 beats discards everything.
    applyStimulus(5, MODE_RAND, 1'b0, 1'b1, 20, 1'b0);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst          = 1'b0;
    i_coeffs_valid = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_obytes", o_obytes, 64'd0);
    checkOutput("mid_rst_valid", 64'(o_obytes_valid), 64'd0);
    checkOutput("mid_rst_ready", 64'(o_coeffs_ready), 64'd0);
    checkOutput("mid_rst_done", 64'(o_done), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    i_coeffs_valid = 1'b0;

    applyStimulus(5, MODE_RAND, 1'b0, 1'b1, 64, 1'b0);
    applyStimulus(3, MODE_RAND, 1'b1, 1'b0, 64, 1'b0);
    applyStimulus(7, MODE_RAND, 1'b0, 1'b1, 64, 1'b0);

    finishTb();
  end

endmodule
